// File: rtl/threshold_block_reader.sv
// threshold_block_reader
// Drains completed blocks from the shared block RAM over an AXI4 read port.
// Each block is BLOCK_DEPTH data words followed by one trailer word. Data words
// stream out through a single-stage valid/ready register. The trailer's low
// byte is checked against a per-block tag table.
module threshold_block_reader #(
    parameter int          WINDOW_WIDTH      = 256,
    parameter int          WINDOW_DEPTH      = 100,
    parameter int          BLOCK_DEPTH_INDEX = 9,
    parameter int          BLOCK_NUM_INDEX   = 4,
    parameter int          BURST_LEN         = 16,
    parameter logic [63:0] PRESET_SEQUENCE   = 64'h08_09_00_01_02_03_04_05
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       enable,
    input  logic [BLOCK_NUM_INDEX-1:0] wr_block_no,
    output logic [BLOCK_NUM_INDEX-1:0] rd_block_no,
    output logic [3:0]                 m_axi_arid,
    output logic [31:0]                m_axi_araddr,
    output logic [7:0]                 m_axi_arlen,
    output logic [2:0]                 m_axi_arsize,
    output logic [1:0]                 m_axi_arburst,
    output logic                       m_axi_arvalid,
    input  logic                       m_axi_arready,
    input  logic [3:0]                 m_axi_rid,
    input  logic [255:0]               m_axi_rdata,
    input  logic [1:0]                 m_axi_rresp,
    input  logic                       m_axi_rlast,
    input  logic                       m_axi_rvalid,
    output logic                       m_axi_rready,
    output logic [WINDOW_WIDTH-1:0]    m_data,
    output logic                       m_valid,
    input  logic                       m_ready,
    output logic                       m_last,
    output logic                       blk_done,
    output logic                       tag_err,
    output logic                       resp_err
);

    localparam int BLOCK_DEPTH = WINDOW_DEPTH * 4;
    localparam logic [BLOCK_DEPTH_INDEX-1:0] LAST_DATA_IDX = BLOCK_DEPTH_INDEX'(BLOCK_DEPTH - 1);
    localparam logic [BLOCK_DEPTH_INDEX-1:0] TRAILER_IDX   = BLOCK_DEPTH_INDEX'(BLOCK_DEPTH);
    localparam logic [BLOCK_DEPTH_INDEX-1:0] DONE_IDX      = BLOCK_DEPTH_INDEX'(BLOCK_DEPTH + 1);
    localparam logic [BLOCK_DEPTH_INDEX-1:0] IDX_ONE       = BLOCK_DEPTH_INDEX'(1);
    localparam logic [BLOCK_NUM_INDEX-1:0]   BLK_ONE       = BLOCK_NUM_INDEX'(1);

    typedef enum logic [1:0] {S_IDLE, S_AR, S_R, S_CHECK} state_t;

    state_t                       state_q;
    logic [BLOCK_NUM_INDEX-1:0]   rd_block_no_q;
    logic [BLOCK_DEPTH_INDEX-1:0] word_idx_q;
    logic                         arvalid_q;
    logic [WINDOW_WIDTH-1:0]      m_data_q;
    logic                         m_valid_q;
    logic                         m_last_q;
    logic                         blk_done_q;
    logic                         tag_err_q;
    logic                         resp_err_q;
    logic [7:0]                   trailer_q;

    logic [31:0]                  remain_d;
    logic [31:0]                  beats_d;
    logic [7:0]                   arlen_d;
    logic                         beat_d;
    logic [BLOCK_DEPTH_INDEX-1:0] word_inc_d;
    logic [7:0]                   trailer_byte_d;
    logic [7:0]                   exp_tag_d;
    logic                         unused_rid;

    assign unused_rid = &{1'b0, m_axi_rid};

    // Burst length: up to BURST_LEN beats, clipped so the last burst ends on the trailer.
    always_comb begin
        remain_d = 32'(BLOCK_DEPTH + 1) - 32'(word_idx_q);
        beats_d  = (remain_d > 32'(BURST_LEN)) ? 32'(BURST_LEN) : remain_d;
        arlen_d  = 8'(beats_d - 32'd1);
    end

    // The trailer beat is always taken; data beats only when the output register can accept.
    assign m_axi_rready   = (state_q == S_R) &&
                            ((word_idx_q == TRAILER_IDX) || !m_valid_q || m_ready);
    assign beat_d         = m_axi_rvalid && m_axi_rready;
    assign word_inc_d     = word_idx_q + IDX_ONE;
    // The trailer is normally the final beat itself, so compare against the live byte then.
    assign trailer_byte_d = (word_idx_q == TRAILER_IDX) ? m_axi_rdata[7:0] : trailer_q;
    assign exp_tag_d      = PRESET_SEQUENCE[{rd_block_no_q[2:0], 3'b000} +: 8];

    // Read FSM plus the output register; blk_done/tag_err are registered on the final
    // beat so they appear during the CHECK cycle.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            rd_block_no_q <= '0;
            word_idx_q    <= '0;
            arvalid_q     <= 1'b0;
            m_data_q      <= '0;
            m_valid_q     <= 1'b0;
            m_last_q      <= 1'b0;
            blk_done_q    <= 1'b0;
            tag_err_q     <= 1'b0;
            resp_err_q    <= 1'b0;
            trailer_q     <= '0;
        end else begin
            blk_done_q <= 1'b0;
            tag_err_q  <= 1'b0;
            if (m_valid_q && m_ready) begin
                m_valid_q <= 1'b0;
            end
            case (state_q)
                S_IDLE: begin
                    if (enable && (rd_block_no_q != wr_block_no)) begin
                        word_idx_q <= '0;
                        arvalid_q  <= 1'b1;
                        state_q    <= S_AR;
                    end
                end
                S_AR: begin
                    if (m_axi_arready) begin
                        arvalid_q <= 1'b0;
                        state_q   <= S_R;
                    end
                end
                S_R: begin
                    if (beat_d) begin
                        word_idx_q <= word_inc_d;
                        if (m_axi_rresp != 2'b00) begin
                            resp_err_q <= 1'b1;
                        end
                        if (word_idx_q < TRAILER_IDX) begin
                            m_data_q  <= m_axi_rdata[WINDOW_WIDTH-1:0];
                            m_last_q  <= (word_idx_q == LAST_DATA_IDX);
                            m_valid_q <= 1'b1;
                        end else if (word_idx_q == TRAILER_IDX) begin
                            trailer_q <= m_axi_rdata[7:0];
                        end
                        if (m_axi_rlast) begin
                            if (word_inc_d == DONE_IDX) begin
                                blk_done_q <= 1'b1;
                                tag_err_q  <= (trailer_byte_d != exp_tag_d);
                                state_q    <= S_CHECK;
                            end else begin
                                arvalid_q <= 1'b1;
                                state_q   <= S_AR;
                            end
                        end
                    end
                end
                S_CHECK: begin
                    rd_block_no_q <= rd_block_no_q + BLK_ONE;
                    state_q       <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign rd_block_no   = rd_block_no_q;
    assign m_axi_arid    = 4'd0;
    assign m_axi_araddr  = 32'({rd_block_no_q, word_idx_q});
    assign m_axi_arlen   = arlen_d;
    assign m_axi_arsize  = 3'b101;
    assign m_axi_arburst = 2'b01;
    assign m_axi_arvalid = arvalid_q;
    assign m_data        = m_data_q;
    assign m_valid       = m_valid_q;
    assign m_last        = m_last_q;
    assign blk_done      = blk_done_q;
    assign tag_err       = tag_err_q;
    assign resp_err      = resp_err_q;

endmodule
